// File: rtl/first_system_pkg.sv
// Shared definitions for the first_system self-check sequencer: FSM state
// encoding, vector count and the golden datapath function. The golden
// function is also available to bench scoreboards.
package first_system_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 4;

    // Golden first_system behaviour: {in1, in2} -> {out1, out2}
    function automatic logic [1:0] golden(input logic [1:0] ins);
        return {ins[1] | ins[0], ~ins[0]};
    endfunction

endpackage

// File: rtl/first_system_checker.sv
// Registered compare of the datapath outputs against the golden pair for the
// vector currently being driven. The flag is loaded on the last settle edge,
// so it is valid only during the CHECK cycle and zero everywhere else.
module first_system_checker
    import first_system_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sample,
    input  logic drv_in1,
    input  logic drv_in2,
    input  logic dut_out1,
    input  logic dut_out2,
    output logic mismatch
);

    // Capture the compare result on the sampling edge; clear it otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch <= 1'b0;
        end else if (sample) begin
            mismatch <= ({dut_out1, dut_out2} != golden({drv_in1, drv_in2}));
        end else begin
            mismatch <= 1'b0;
        end
    end

endmodule

// File: rtl/first_system_sequencer.sv
// Drives all four input combinations into the first_system datapath, lets
// each one settle for SETTLE_CYCLES, checks the outputs and reports a
// pass/fail summary with a per-vector failure map. Every output is a flop.
module first_system_sequencer
    import first_system_pkg::*;
#(
    parameter int SETTLE_CYCLES = 3
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec,
    output logic       drv_in1,
    output logic       drv_in2,
    input  logic       dut_out1,
    input  logic       dut_out2
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [1:0] LAST_VEC    = 2'(NUM_VECTORS - 1);

    state_t     state;
    logic [1:0] vec;
    logic [3:0] cnt;
    logic       sample;
    logic       mismatch;

    // The datapath outputs are captured on the edge that ends the settle
    // window, giving the vector SETTLE_CYCLES full cycles of stability.
    assign sample = (state == ST_SETTLE) && (cnt == 4'd1);

    first_system_checker u_checker (
        .clk      (clk),
        .rst      (rst),
        .sample   (sample),
        .drv_in1  (drv_in1),
        .drv_in2  (drv_in2),
        .dut_out1 (dut_out1),
        .dut_out2 (dut_out2),
        .mismatch (mismatch)
    );

    // Sequencer FSM with counters, drive and result registers
    // NOTE: all state here uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only a handful of control flops exist, so every one of
            // them is reset; there is no storage array that could be left out.
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
            drv_in1   <= 1'b0;
            drv_in2   <= 1'b0;
            vec       <= 2'd0;
            cnt       <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        vec                <= 2'd0;
                        {drv_in1, drv_in2} <= 2'd0;
                        cnt                <= SETTLE_LOAD;
                        err_count          <= 3'd0;
                        fail_vec           <= 4'd0;
                        pass               <= 1'b0;
                        busy               <= 1'b1;
                        state              <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        err_count     <= err_count + 3'd1;
                        fail_vec[vec] <= 1'b1;
                    end
                    if (vec == LAST_VEC) begin
                        // Result includes the vector being checked right now
                        pass  <= (err_count == 3'd0) && !mismatch;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        vec                <= vec + 2'd1;
                        {drv_in1, drv_in2} <= vec + 2'd1;
                        cnt                <= SETTLE_LOAD;
                        state              <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_first_system_sequencer.sv
// Bench for first_system_sequencer. Two sequencers run side by side: dut_a
// with the default settle time and dut_b with SETTLE_CYCLES=1. Each one sees
// its own behavioural datapath whose fault mode is selected per scenario.
// Expected results come from plain per-vector reasoning about the datapath.
module tb_first_system_sequencer;

    typedef enum int {M_IDEAL, M_STUCK, M_DELAY, M_RAND} mode_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    mode_t      mode;
    logic [3:0] c1, c2;            // per-vector corruption masks for M_RAND

    logic       a_busy, a_done, a_pass, a_drv1, a_drv2, a_out1, a_out2;
    logic [2:0] a_err;
    logic [3:0] a_fv;
    logic       b_busy, b_done, b_pass, b_drv1, b_drv2, b_out1, b_out2;
    logic [2:0] b_err;
    logic [3:0] b_fv;
    logic       a_q1, a_q2, b_q1, b_q2;

    int checks = 0;
    int errors = 0;
    int a_dones[$];
    int b_dones[$];
    int a_idle[$];
    logic a_busy0;

    always #5 clk = ~clk;

    first_system_sequencer dut_a (
        .clk(clk), .rst(rst), .start(start),
        .busy(a_busy), .done(a_done), .pass(a_pass),
        .err_count(a_err), .fail_vec(a_fv),
        .drv_in1(a_drv1), .drv_in2(a_drv2),
        .dut_out1(a_out1), .dut_out2(a_out2)
    );

    first_system_sequencer #(.SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .start(start),
        .busy(b_busy), .done(b_done), .pass(b_pass),
        .err_count(b_err), .fail_vec(b_fv),
        .drv_in1(b_drv1), .drv_in2(b_drv2),
        .dut_out1(b_out1), .dut_out2(b_out2)
    );

    // Datapath models: out2 pipeline used by the two-cycle-delay mode
    always @(posedge clk) begin
        a_q1 <= ~a_drv2;
        a_q2 <= a_q1;
        b_q1 <= ~b_drv2;
        b_q2 <= b_q1;
    end

    always_comb begin
        a_out1 = a_drv1 | a_drv2;
        a_out2 = ~a_drv2;
        b_out1 = b_drv1 | b_drv2;
        b_out2 = ~b_drv2;
        case (mode)
            M_STUCK: begin
                a_out2 = 1'b0;
                b_out2 = 1'b0;
            end
            M_DELAY: begin
                a_out2 = a_q2;
                b_out2 = b_q2;
            end
            M_RAND: begin
                a_out1 = a_out1 ^ c1[{a_drv1, a_drv2}];
                a_out2 = a_out2 ^ c2[{a_drv1, a_drv2}];
                b_out1 = b_out1 ^ c1[{b_drv1, b_drv2}];
                b_out2 = b_out2 ^ c2[{b_drv1, b_drv2}];
            end
            default: ;
        endcase
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Raise start so the next rising edge is the capture edge (cycle 0 follows it)
    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Observe ncycles cycles after capture, logging done pulses and idle cycles
    task automatic watch(input int ncycles, input int hold, input int rp0,
                         input int rp1, input int rst_at);
        a_dones.delete();
        b_dones.delete();
        a_idle.delete();
        for (int k = 0; k < ncycles; k++) begin
            @(negedge clk);
            if (a_done) a_dones.push_back(k);
            if (b_done) b_dones.push_back(k);
            if (!a_busy) a_idle.push_back(k);
            if (k == 0) a_busy0 = a_busy;
            start = (k < hold) || (k == rp0) || (k == rp1);
            rst   = (k == rst_at);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({a_busy, a_done, a_pass, a_err, a_fv, a_drv1, a_drv2} !== 12'd0) begin
            errors++;
            $display("FAIL reset_a outputs got %b want 0", {a_busy, a_done, a_pass, a_err, a_fv, a_drv1, a_drv2});
        end
        checks++;
        if ({b_busy, b_done, b_pass, b_err, b_fv, b_drv1, b_drv2} !== 12'd0) begin
            errors++;
            $display("FAIL reset_b outputs got %b want 0", {b_busy, b_done, b_pass, b_err, b_fv, b_drv1, b_drv2});
        end
    endtask

    task automatic test_ideal();
        mode = M_IDEAL;
        start_pulse();
        watch(24, 0, -1, -1, -1);
        checks++;
        if (a_busy0 !== 1'b1) begin
            errors++;
            $display("FAIL ideal_busy_at_capture got %b want 1", a_busy0);
        end
        checks++;
        if (a_dones.size() != 1 || a_dones[0] != 16) begin
            errors++;
            $display("FAIL ideal_done_cycle_a got n=%0d first=%0d want n=1 first=16",
                     a_dones.size(), (a_dones.size() > 0) ? a_dones[0] : -1);
        end
        checks++;
        if (b_dones.size() != 1 || b_dones[0] != 8) begin
            errors++;
            $display("FAIL ideal_done_cycle_b got n=%0d first=%0d want n=1 first=8",
                     b_dones.size(), (b_dones.size() > 0) ? b_dones[0] : -1);
        end
        checks++;
        if ({a_pass, a_err, a_fv} !== {1'b1, 3'd0, 4'b0000}) begin
            errors++;
            $display("FAIL ideal_result_a got pass=%b err=%0d fv=%b want 1 0 0000", a_pass, a_err, a_fv);
        end
        checks++;
        if ({a_drv1, a_drv2, a_busy} !== 3'b110) begin
            errors++;
            $display("FAIL ideal_hold_vec3 got drv=%b%b busy=%b want 11 0", a_drv1, a_drv2, a_busy);
        end
    endtask

    task automatic test_stuck();
        logic [3:0] want_fv;
        mode = M_STUCK;
        // out2 stuck at 0 is wrong exactly where ~in2 is 1, i.e. in2 = 0
        for (int i = 0; i < 4; i++) want_fv[i] = ((i % 2) == 0);
        start_pulse();
        watch(24, 0, -1, -1, -1);
        checks++;
        if ({a_pass, a_err, a_fv} !== {1'b0, 3'($countones(want_fv)), want_fv}) begin
            errors++;
            $display("FAIL stuck_result_a got pass=%b err=%0d fv=%b want 0 %0d %b",
                     a_pass, a_err, a_fv, $countones(want_fv), want_fv);
        end
        checks++;
        if ({b_pass, b_err, b_fv} !== {1'b0, 3'($countones(want_fv)), want_fv}) begin
            errors++;
            $display("FAIL stuck_result_b got pass=%b err=%0d fv=%b want 0 %0d %b",
                     b_pass, b_err, b_fv, $countones(want_fv), want_fv);
        end
    endtask

    task automatic test_delay();
        logic [3:0] want_fv;
        logic       prev_in2;
        do_reset();
        mode = M_DELAY;
        // With one settle cycle the sampled out2 still reflects the previous
        // drive (vector "-1" is the all-zero reset drive); a vector fails when
        // its in2 differs from that. Three settle cycles cover the delay.
        prev_in2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            want_fv[i] = ((i % 2) != int'(prev_in2));
            prev_in2   = ((i % 2) == 1);
        end
        start_pulse();
        watch(24, 0, -1, -1, -1);
        checks++;
        if ({b_pass, b_err, b_fv} !== {1'b0, 3'($countones(want_fv)), want_fv}) begin
            errors++;
            $display("FAIL delay_settle1 got pass=%b err=%0d fv=%b want 0 %0d %b",
                     b_pass, b_err, b_fv, $countones(want_fv), want_fv);
        end
        checks++;
        if ({a_pass, a_err, a_fv} !== {1'b1, 3'd0, 4'b0000}) begin
            errors++;
            $display("FAIL delay_settle3 got pass=%b err=%0d fv=%b want 1 0 0000", a_pass, a_err, a_fv);
        end
    endtask

    task automatic test_start_ignored();
        mode = M_IDEAL;
        start_pulse();
        watch(30, 0, 5, 10, -1);
        checks++;
        if (a_dones.size() != 1 || a_dones[0] != 16) begin
            errors++;
            $display("FAIL repulse_done got n=%0d first=%0d want n=1 first=16",
                     a_dones.size(), (a_dones.size() > 0) ? a_dones[0] : -1);
        end
        checks++;
        if ({a_pass, a_err, a_fv} !== {1'b1, 3'd0, 4'b0000}) begin
            errors++;
            $display("FAIL repulse_result got pass=%b err=%0d fv=%b want 1 0 0000", a_pass, a_err, a_fv);
        end
    endtask

    task automatic test_mid_reset();
        mode = M_STUCK;   // a run with failures so cleared results are visible
        start_pulse();
        watch(8, 0, -1, -1, 7);
        checks++;
        if ({a_busy, a_done, a_pass, a_err, a_fv, a_drv1, a_drv2} !== 12'd0) begin
            errors++;
            $display("FAIL midreset_a got %b want 0", {a_busy, a_done, a_pass, a_err, a_fv, a_drv1, a_drv2});
        end
        checks++;
        if ({b_busy, b_done, b_pass, b_err, b_fv, b_drv1, b_drv2} !== 12'd0) begin
            errors++;
            $display("FAIL midreset_b got %b want 0", {b_busy, b_done, b_pass, b_err, b_fv, b_drv1, b_drv2});
        end
        rst = 1'b0;
        watch(25, 0, -1, -1, -1);
        checks++;
        if (a_dones.size() != 0 || b_dones.size() != 0) begin
            errors++;
            $display("FAIL midreset_no_done got a=%0d b=%0d want 0 0", a_dones.size(), b_dones.size());
        end
        mode = M_IDEAL;
        start_pulse();
        watch(20, 0, -1, -1, -1);
        checks++;
        if (a_dones.size() != 1 || a_dones[0] != 16 || a_pass !== 1'b1) begin
            errors++;
            $display("FAIL midreset_rerun got n=%0d pass=%b want n=1 at 16 pass=1", a_dones.size(), a_pass);
        end
    endtask

    task automatic test_back_to_back();
        int idle_in_runs;
        int idle_at;
        mode = M_IDEAL;
        start_pulse();
        watch(60, 40, -1, -1, -1);
        // Second run: DONE cycle 16, one IDLE cycle 17, capture ends it, then a full run
        checks++;
        if (a_dones.size() < 2 || a_dones[0] != 16 || a_dones[1] != 16 + 2 + 16) begin
            errors++;
            $display("FAIL b2b_done_cycles got n=%0d d0=%0d d1=%0d want 16 34",
                     a_dones.size(), (a_dones.size() > 0) ? a_dones[0] : -1,
                     (a_dones.size() > 1) ? a_dones[1] : -1);
        end
        idle_in_runs = 0;
        idle_at      = -1;
        foreach (a_idle[i]) begin
            if (a_idle[i] <= 34) begin
                idle_in_runs++;
                idle_at = a_idle[i];
            end
        end
        checks++;
        if (idle_in_runs != 1 || idle_at != 17) begin
            errors++;
            $display("FAIL b2b_busy_gap got n=%0d at=%0d want n=1 at=17", idle_in_runs, idle_at);
        end
    endtask

    task automatic test_random();
        logic [3:0] want_fv;
        mode = M_RAND;
        for (int r = 0; r < 10; r++) begin
            c1 = 4'($urandom_range(0, 15));
            c2 = 4'($urandom_range(0, 15));
            if (r == 0) begin
                c1 = 4'b1001;   // both outputs bad on vector 0: counted once
                c2 = 4'b0001;
            end
            want_fv = c1 | c2;
            start_pulse();
            watch(20, 0, -1, -1, -1);
            checks++;
            if ({a_pass, a_err, a_fv} !== {want_fv == 4'd0, 3'($countones(want_fv)), want_fv}) begin
                errors++;
                $display("FAIL random_a[%0d] c1=%b c2=%b got pass=%b err=%0d fv=%b want %b %0d %b",
                         r, c1, c2, a_pass, a_err, a_fv, want_fv == 4'd0, $countones(want_fv), want_fv);
            end
            checks++;
            if ({b_pass, b_err, b_fv} !== {want_fv == 4'd0, 3'($countones(want_fv)), want_fv}) begin
                errors++;
                $display("FAIL random_b[%0d] c1=%b c2=%b got pass=%b err=%0d fv=%b want %b %0d %b",
                         r, c1, c2, b_pass, b_err, b_fv, want_fv == 4'd0, $countones(want_fv), want_fv);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = M_IDEAL;
        c1    = 4'd0;
        c2    = 4'd0;
        test_reset();
        test_ideal();
        test_stuck();
        test_delay();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
